pwm_bank: RTL and testbench

- Parametrised N-channel PWM generator; the successor to the two-channel, fixed-32-bit PWM used by the cube-motor/servo drivers.
- Each channel has its own period counter, shadow-buffered period/duty registers, enable, output polarity and an edge-/center-aligned mode.
- Sits between the control register file (or the sequencing FSM) and the motor/servo driver pins.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_channel.sv | 78 +++++++
 rtl/pwm_bank.sv | 40 ++++
 tb/tb_pwm_bank.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode encodings, default width and flattened-bus field slicing for the PWM bank.
package pwm_pkg;
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam int   CNT_W_DEF   = 32;
    localparam int   MAX_CH      = 32;
    localparam int   MAX_W       = 64;
    localparam int   BUS_W       = MAX_CH * MAX_W;

    function automatic logic [MAX_W-1:0] field(input logic [BUS_W-1:0] bus, input int unsigned i,
                                               input int unsigned w);
        return MAX_W'(bus >> (i * w)) & ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel with period counter, shadow period/duty and registered compare output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             pol_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o,
    output logic             pend_o,
    output logic             prd_end_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, duty_q, duty_d, pper_q, pper_d, pduty_q, pduty_d;
    logic             dir_q, dir_d, pend_q, pend_d, mode_q, mode_d, run_q, pwm_q, pwm_d, end_q;
    logic             vld_q, dn, bnd, xfer;

    always_comb begin
        dn = mode_q == MODE_CENTER && per_q != '0 && (dir_q || cnt_q == per_q);
        bnd = (mode_q == MODE_CENTER && per_q != '0) ? dn && cnt_q == CNT_W'(1) : cnt_q == per_q;
        cnt_d = bnd ? '0 : dn ? cnt_q - 1'b1 : cnt_q + 1'b1;
        dir_d = dn && cnt_q != CNT_W'(1);
        // the first enabled edge after a disable restarts the period at 0 without counting
        if (!en_i || !run_q) begin
            cnt_d = '0;
            dir_d = 1'b0;
            bnd   = 1'b0;
        end
        xfer    = !en_i || bnd;
        per_d   = xfer ? pper_q : per_q;
        duty_d  = xfer ? pduty_q : duty_q;
        pper_d  = load_i ? period_i : pper_q;
        pduty_d = load_i ? duty_i : pduty_q;
        pend_d  = load_i || (pend_q && !xfer);
        mode_d  = (xfer || !run_q) ? mode_i : mode_q;
        pwm_d   = en_i ? (cnt_d < duty_d) ^ pol_i : pol_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            per_q   <= '0;
            duty_q  <= '0;
            pper_q  <= '0;
            pduty_q <= '0;
            pend_q  <= 1'b0;
            mode_q  <= MODE_EDGE;
            run_q   <= 1'b0;
            pwm_q   <= 1'b0;
            end_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            per_q   <= per_d;
            duty_q  <= duty_d;
            pper_q  <= pper_d;
            pduty_q <= pduty_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            run_q   <= en_i;
            pwm_q   <= pwm_d;
            end_q   <= bnd;
            vld_q   <= 1'b1;
        end
    end

    // until the first edge after reset the output rests at the inactive level
    assign pwm_o     = vld_q ? pwm_q : pol_i;
    assign pend_o    = pend_q;
    assign prd_end_o = end_q;
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: NUM_CH independent PWM channels fed from flattened period/duty buses.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH-1:0]       pol_i,
    input  logic [NUM_CH*CNT_W-1:0] period_i,
    input  logic [NUM_CH*CNT_W-1:0] duty_i,
    input  logic [NUM_CH-1:0]       load_i,
    output logic [NUM_CH-1:0]       pwm_o,
    output logic [NUM_CH-1:0]       pend_o,
    output logic [NUM_CH-1:0]       prd_end_o
);
    logic [BUS_W-1:0] per_ext, duty_ext;

    assign per_ext  = BUS_W'(period_i);
    assign duty_ext = BUS_W'(duty_i);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (en_i[g]),
            .mode_i   (mode_i[g]),
            .pol_i    (pol_i[g]),
            .load_i   (load_i[g]),
            .period_i (CNT_W'(field(per_ext, g, CNT_W))),
            .duty_i   (CNT_W'(field(duty_ext, g, CNT_W))),
            .pwm_o    (pwm_o[g]),
            .pend_o   (pend_o[g]),
            .prd_end_o(prd_end_o[g])
        );
    end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed vectors with hand-computed expected waveforms for pwm_bank.
module tb_pwm_bank;
    logic         clk, rst_n;
    logic [7:0]   en, mode, pol, load, pwm_o, pend_o, prd_end_o;
    logic [255:0] period, duty;
    logic [31:0]  pw, pe, pd;
    int           n_vec = 0, n_err = 0;
    logic [7:0]   mc_exp [7] = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h05, 8'h08, 8'h13};

    pwm_bank #(.NUM_CH(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .pol_i(pol),
        .period_i(period), .duty_i(duty), .load_i(load),
        .pwm_o(pwm_o), .pend_o(pend_o), .prd_end_o(prd_end_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] p, input logic [31:0] d);
        period[c*32 +: 32] = p;
        duty[c*32 +: 32]   = d;
    endtask

    task automatic capture(input int n, input int ch);
        pw = '0; pe = '0; pd = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            load = '0;
            pw[i] = pwm_o[ch];
            pe[i] = prd_end_o[ch];
            pd[i] = pend_o[ch];
        end
    endtask

    initial begin
        rst_n = 1'b0; en = '0; mode = '0; pol = 8'hA5; load = '0; period = '0; duty = '0;
        #2;
        check("rst_pwm", pwm_o, 8'hA5);
        check("rst_pend", pend_o, 0);
        check("rst_end", prd_end_o, 0);
        #10 rst_n = 1'b1;
        pol = '0;
        set_ch(0, 9, 3); load[0] = 1'b1;
        tick(); load = '0;
        check("ld_pend", pend_o[0], 1);
        tick();
        check("xfer_pend", pend_o[0], 0);
        check("dis_pwm", pwm_o[0], 0);
        en[0] = 1'b1;
        capture(20, 0);
        check("edge_pwm", pw, 32'h0001C07);
        check("edge_end", pe, 32'h0000400);
        repeat (3) tick();
        set_ch(0, 4, 4); load[0] = 1'b1;
        capture(16, 0);
        check("upd_pwm", pw, 32'hF780);
        check("upd_pend", pd, 32'h007F);
        check("upd_end", pe, 32'h1080);
        en[0] = 1'b0; mode[0] = 1'b1; set_ch(0, 4, 2); load[0] = 1'b1;
        tick(); load = '0;
        tick();
        check("ctr_pend", pend_o[0], 0);
        en[0] = 1'b1;
        capture(16, 0);
        check("ctr_pwm", pw, 32'h8383);
        check("ctr_end", pe, 32'h0100);
        en[0] = 1'b0;
        tick();
        check("off_pwm", pwm_o[0], 0);
        check("off_end", prd_end_o[0], 0);
        en[0] = 1'b1;
        capture(8, 0);
        check("reen_pwm", pw, 32'h83);
        en[2:1] = 2'b00; set_ch(1, 9, 0); set_ch(2, 9, 12); load = 8'h06;
        tick(); load = '0;
        tick();
        en[2:1] = 2'b11;
        capture(12, 1);
        check("d0_pwm", pw, 32'h000);
        capture(12, 2);
        check("dmax_pwm", pw, 32'hFFF);
        pol[2:1] = 2'b11;
        #1;
        check("pol_hold", pwm_o[2:1], 2'b10);
        tick();
        check("pol_edge", pwm_o[2:1], 2'b01);
        en = '0; mode = '0; pol = '0;
        for (int k = 0; k < 8; k++) set_ch(k, k + 1, 1);
        load = 8'hFF;
        tick(); load = '0;
        tick();
        check("mc_pend", pend_o, 0);
        en = 8'hFF;
        for (int j = 0; j < 7; j++) begin
            tick();
            check($sformatf("mc_pwm%0d", j), pwm_o, mc_exp[j]);
        end
        pol = 8'h5A;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pwm", pwm_o, 8'h5A);
        check("arst_pend", pend_o, 0);
        check("arst_end", prd_end_o, 0);
        #3 rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            check($sformatf("post_rst%0d", j), pwm_o, 8'h5A);
        end
        check("post_pend", pend_o, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
